sample_feeder: RTL and testbench
================================

// Module: sample_feeder
// PURPOSE
//   Upstream stage of top_filter. Buffers samples from an ADC-side valid/ready stream in a small
//   FIFO and releases one sample per sample period: drives the filter's data_in and generates its
//   sample_trig strobe from a clock divider. Keeps the filter rate constant on source underrun.
// PARAMETERS
//   DATA_SIZE  24  sample width, two's complement, passed through unchanged
//   DIV        50  clk cycles per sample period; DIV >= TRIG_LEN+2
//   TRIG_LEN   3   sample_trig high time in clk cycles; TRIG_LEN >= 1
//   FIFO_DEPTH 8   FIFO entries, power of two >= 2; FIFO_AW = $clog2(FIFO_DEPTH) is a localparam
// PORTS
//   clk          in   1             system clock, all logic on rising edge
//   reset        in   1             synchronous, active-low reset
//   in_data      in   DATA_SIZE     sample from source
//   in_valid     in   1             in_data valid
//   in_ready     out  1             FIFO can accept; = !full (combinational from registered level)
//   data_out     out  DATA_SIZE     to top_filter data_in; changes only on the trig rising edge
//   sample_trig  out  1             to top_filter sample_trig; TRIG_LEN-cycle pulse per period
//   underflow    out  1             1-cycle pulse: period tick found FIFO empty
//   fifo_level   out  FIFO_AW+1     current FIFO occupancy, 0..FIFO_DEPTH
// BEHAVIOUR
//   Reset (reset==0 at clk edge): div_cnt=0, FIFO flushed (level 0, pointers 0), data_out=0,
//     sample_trig=0, underflow=0, FSM=S_WAIT. Applies mid-operation: an active pulse ends at that edge.
//   Push: in_valid && in_ready -> write at wr_ptr, wr_ptr wraps mod FIFO_DEPTH. in_ready=0 at level
//     FIFO_DEPTH; source must hold in_data/in_valid until accepted.
//   Divider: div_cnt counts 0..DIV-1 and wraps; tick = (div_cnt==DIV-1). First tick at the 50th
//     clk after reset release (DIV=50); period exactly DIV cycles thereafter.
//   On tick, registered at the same edge:
//     level>0: pop head -> data_out, rd_ptr advances, sample_trig<=1.
//     level==0: data_out holds previous value, sample_trig<=1 (repeat sample), underflow<=1.
//   FSM: S_WAIT --tick--> S_TRIG (trig_cnt=0); S_TRIG: trig_cnt++, sample_trig=1; at
//     trig_cnt==TRIG_LEN-1 -> S_WAIT, sample_trig<=0. Pulse width exactly TRIG_LEN cycles.
//   Simultaneous push+pop: level unchanged, both pointers advance. Push into empty FIFO on the
//     tick edge is not bypassed: that tick still underflows; word pops next period.
//   Full with tick: pop frees a slot; in_ready rises the following cycle.
//   fifo_level updates on the edge of the push/pop; never exceeds FIFO_DEPTH or drops below 0.
// CONFIGURATION
//   SAMPLE_FEEDER_UFCNT_EN defined: adds output port underflow_cnt [15:0], reset 0, +1 per
//     underflow pulse, saturates at 16'hFFFF.
//   Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//   Header filtr_defs.vh (shared with top_filter): DATA_SIZE default, DIV/TRIG_LEN defaults,
//     FSM state encodings S_WAIT=1'b0, S_TRIG=1'b1.
//   Sub-module sample_fifo (sync FIFO, DATA_SIZE x FIFO_DEPTH, level/full/empty outputs);
//     divider, trigger FSM and output register live in sample_feeder.
// TESTING  (DIV=50, TRIG_LEN=3, FIFO_DEPTH=8 unless stated)
//   1 Reset: reset=0 for 5 clks -> data_out=0, sample_trig=0, underflow=0, fifo_level=0; in_ready=1
//     after release.
//   2 Stream: push 24'h000001..24'h000004 at t=0 -> trig rises at clk 50,100,150,200 after release,
//     high 3 clks each; data_out=1,2,3,4 at those edges; no underflow.
//   3 Full: push 9 words, no tick in window -> in_ready=0 after 8th, fifo_level=8, 9th held and
//     accepted the cycle after the next pop.
//   4 Underflow: empty FIFO at tick after data_out=24'h000004 -> data_out stays 4, trig still
//     3 clks, underflow 1 clk; with SAMPLE_FEEDER_UFCNT_EN underflow_cnt=1.
//   5 Push on tick edge at level 3 -> fifo_level stays 3, popped word = oldest; push on tick at
//     level 0 -> underflow, level 1.
//   6 Reset mid-pulse: reset=0 on 2nd trig cycle -> sample_trig=0, fifo_level=0, data_out=0 next
//     edge; next trig 50 clks after release.

Source files
------------

// File: rtl/sample_feeder_pkg.sv
// sample_feeder_pkg
//   Shared definitions for the sample feeder: parameter defaults that match
//   top_filter, the trigger FSM state encoding and a counter-width helper.
//   Optional feature macro used elsewhere in this slice: SAMPLE_FEEDER_UFCNT_EN.
package sample_feeder_pkg;

  localparam int DATA_SIZE_DEF  = 24;
  localparam int DIV_DEF        = 50;
  localparam int TRIG_LEN_DEF   = 3;
  localparam int FIFO_DEPTH_DEF = 8;

  // Encodings are shared with top_filter, so they are fixed explicitly.
  typedef enum logic {
    S_WAIT = 1'b0,
    S_TRIG = 1'b1
  } trig_state_t;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sample_feeder_if.sv
// sample_feeder_if
//   ADC-side valid/ready sample stream into the feeder.
//   in_data  : sample, two's complement, DATA_SIZE bits
//   in_valid : in_data valid, held by the source until accepted
//   in_ready : feeder can accept this cycle
//   Modports: master = source side, slave = feeder side.
interface sample_feeder_if #(
  parameter int DATA_SIZE = 24
);
  logic [DATA_SIZE-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sample_feeder_fifo.sv
// sample_fifo
//   Synchronous FIFO, DATA_SIZE x FIFO_DEPTH (power of two). Flush on reset
//   clears pointers and level only; storage is not cleared.
//   Ports:
//     clk, reset          clock, synchronous active-low reset
//     wr_en, wr_data      write request (ignored while full)
//     rd_en               read request (ignored while empty)
//     rd_data             head entry, valid while !empty
//     level               occupancy 0..FIFO_DEPTH
//     full, empty         status from the registered level
module sample_fifo #(
  parameter  int DATA_SIZE  = 24,
  parameter  int FIFO_DEPTH = 8,
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic [FIFO_AW:0]     level,
  output logic                 full,
  output logic                 empty
);

  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic                 do_wr;
  logic                 do_rd;

  assign full    = (level == (FIFO_AW+1)'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sample_feeder.sv
// sample_feeder
//   Upstream stage of top_filter. Buffers source samples in a small FIFO and
//   releases one per sample period of DIV clocks, driving data_out and a
//   TRIG_LEN-cycle sample_trig strobe. On source underrun the previous sample
//   is repeated and underflow pulses, so the filter rate stays constant.
//   Optional feature: define SAMPLE_FEEDER_UFCNT_EN to add underflow_cnt.
//   Ports:
//     clk            system clock, rising edge
//     reset          synchronous active-low reset
//     sif            sample stream in (slave modport: in_data/in_valid/in_ready)
//     data_out       to top_filter data_in, changes only on trig rising edge
//     sample_trig    to top_filter sample_trig
//     underflow      1-cycle pulse when a period tick finds the FIFO empty
//     fifo_level     FIFO occupancy 0..FIFO_DEPTH
//     underflow_cnt  (SAMPLE_FEEDER_UFCNT_EN only) saturating underflow count
//
//   state  | meaning
//   S_WAIT | strobe low, waiting for the divider tick
//   S_TRIG | strobe high, counting TRIG_LEN cycles
module sample_feeder
  import sample_feeder_pkg::*;
#(
  parameter  int DATA_SIZE  = DATA_SIZE_DEF,
  parameter  int DIV        = DIV_DEF,
  parameter  int TRIG_LEN   = TRIG_LEN_DEF,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  sample_feeder_if.slave       sif,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 sample_trig,
  output logic                 underflow,
  output logic [FIFO_AW:0]     fifo_level
`ifdef SAMPLE_FEEDER_UFCNT_EN
  ,
  output logic [15:0]          underflow_cnt
`endif
);

  localparam int DIV_W  = cnt_w(DIV);
  localparam int TRIG_W = cnt_w(TRIG_LEN);

  logic [DIV_W-1:0]     div_cnt;
  logic [TRIG_W-1:0]    trig_cnt;
  trig_state_t          state;
  logic                 tick;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_SIZE-1:0] fifo_rd_data;
  logic                 push;
  logic                 pop;
  logic                 uf_event;

  assign tick = (div_cnt == DIV_W'(DIV - 1));

  // A push on the tick edge into an empty FIFO is not bypassed: empty is
  // the registered status, so that tick still underflows.
  assign push     = sif.in_valid && !fifo_full;
  assign pop      = tick && (state == S_WAIT) && !fifo_empty;
  assign uf_event = tick && (state == S_WAIT) && fifo_empty;

  assign sif.in_ready = !fifo_full;

  sample_fifo #(
    .DATA_SIZE  (DATA_SIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (sif.in_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt     <= '0;
      trig_cnt    <= '0;
      state       <= S_WAIT;
      data_out    <= '0;
      sample_trig <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      div_cnt   <= tick ? '0 : div_cnt + 1'b1;
      underflow <= 1'b0;
      case (state)
        S_WAIT: begin
          if (tick) begin
            state       <= S_TRIG;
            trig_cnt    <= '0;
            sample_trig <= 1'b1;
            if (pop) begin
              data_out <= fifo_rd_data;
            end
            if (uf_event) begin
              underflow <= 1'b1;
            end
          end
        end
        S_TRIG: begin
          if (trig_cnt == TRIG_W'(TRIG_LEN - 1)) begin
            state       <= S_WAIT;
            sample_trig <= 1'b0;
          end else begin
            trig_cnt <= trig_cnt + 1'b1;
          end
        end
        default: begin
          state       <= S_WAIT;
          sample_trig <= 1'b0;
        end
      endcase
    end
  end

`ifdef SAMPLE_FEEDER_UFCNT_EN
  // Counts on the same edge that raises underflow, so the count and the
  // pulse are visible together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      underflow_cnt <= '0;
    end else if (uf_event && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sample_feeder.sv
// tb_sample_feeder
//   Directed bench for sample_feeder (DIV=50, TRIG_LEN=3, FIFO_DEPTH=8).
//   The driver queues the expected sample/underflow for each period; a
//   monitor pops one entry on every sample_trig rising edge and compares.
//   Honours SAMPLE_FEEDER_UFCNT_EN when the design is built with it.
module tb_sample_feeder;

  localparam int DW = 24;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sample_feeder_if #(.DATA_SIZE(DW)) sif ();

  logic [DW-1:0] data_out;
  logic          sample_trig;
  logic          underflow;
  logic [3:0]    fifo_level;
`ifdef SAMPLE_FEEDER_UFCNT_EN
  logic [15:0]   underflow_cnt;
`endif

  sample_feeder #(
    .DATA_SIZE  (DW),
    .DIV        (50),
    .TRIG_LEN   (3),
    .FIFO_DEPTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sif         (sif),
    .data_out    (data_out),
    .sample_trig (sample_trig),
    .underflow   (underflow),
    .fifo_level  (fifo_level)
`ifdef SAMPLE_FEEDER_UFCNT_EN
    ,
    .underflow_cnt (underflow_cnt)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          uf;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;   // clock edges since reset release, maintained by the monitor

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_period(input logic [DW-1:0] d, input logic uf);
    exp_t e;
    e.data = d;
    e.uf   = uf;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int target);
    int b = 0;
    while (cyc != target && b < 5000) begin
      @(negedge clk);
      b++;
    end
    if (cyc != target) begin
      fails++;
      $display("FAIL wait_timeout: cyc %0d expected %0d", cyc, target);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_word(input logic [DW-1:0] d, output int acc_cyc);
    int b = 0;
    sif.in_data  = d;
    sif.in_valid = 1'b1;
    while (!sif.in_ready && b < 2000) begin
      @(negedge clk);
      b++;
    end
    if (!sif.in_ready) begin
      fails++;
      $display("FAIL push_timeout: in_ready stuck low for word %0h", d);
    end
    acc_cyc = cyc + 1;
    @(negedge clk);
    sif.in_valid = 1'b0;
  endtask

  // Monitor: samples #1 after every rising edge.
  initial begin
    logic prev;
    int   width;
    int   ufn;
    exp_t e;
    prev  = 1'b0;
    width = 0;
    ufn   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        cyc   = 0;
        prev  = 1'b0;
        width = 0;
        ufn   = 0;
      end else begin
        cyc++;
        if (sample_trig && !prev) begin
          check("trig_phase", cyc % 50, 0);
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_trig: no expected sample queued at cyc %0d", cyc);
          end else begin
            e = exp_q.pop_front();
            check("data_out", data_out, e.data);
            check("underflow", underflow, e.uf);
            if (e.uf) ufn++;
`ifdef SAMPLE_FEEDER_UFCNT_EN
            check("underflow_cnt", underflow_cnt, ufn);
`endif
          end
          width = 1;
        end else begin
          check("underflow_idle", underflow, 0);
          if (sample_trig) width++;
          else if (prev) check("trig_width", width, 3);
        end
        prev = sample_trig;
      end
    end
  end

  initial begin
    int acc;
    sif.in_valid = 1'b0;
    sif.in_data  = '0;
    reset        = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_data_out", data_out, 0);
    check("rst_trig", sample_trig, 0);
    check("rst_underflow", underflow, 0);
    check("rst_level", fifo_level, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", sif.in_ready, 1);

    // Stream of four, then an underflow repeating the last sample
    for (int i = 1; i <= 4; i++) expect_period(DW'(i), 1'b0);
    expect_period(24'h000004, 1'b1);
    for (int i = 1; i <= 4; i++) push_word(DW'(i), acc);
    check("stream_level", fifo_level, 4);
    wait_cyc(252);

    // Full: eight words fill the FIFO between ticks, the ninth waits for a pop
    for (int i = 1; i <= 9; i++) expect_period(24'hA00000 + DW'(i), 1'b0);
    for (int i = 1; i <= 8; i++) push_word(24'hA00000 + DW'(i), acc);
    check("full_level", fifo_level, 8);
    check("full_in_ready", sif.in_ready, 0);
    push_word(24'hA00009, acc);
    check("full_accept_cyc", acc, 301);
    check("full_level_refill", fifo_level, 8);
    wait_cyc(702);
    check("drained_level", fifo_level, 0);

    // Push on the tick edge at level 3, then at level 0
    expect_period(24'hB00001, 1'b0);
    expect_period(24'hB00002, 1'b0);
    expect_period(24'hB00003, 1'b0);
    expect_period(24'hB00004, 1'b0);
    expect_period(24'hB00004, 1'b1);
    expect_period(24'hC00001, 1'b0);
    push_word(24'hB00001, acc);
    push_word(24'hB00002, acc);
    push_word(24'hB00003, acc);
    check("lvl3_before_tick", fifo_level, 3);
    wait_cyc(749);
    push_word(24'hB00004, acc);
    check("tick_push_cyc", acc, 750);
    check("tick_push_level3", fifo_level, 3);
    wait_cyc(949);
    push_word(24'hC00001, acc);
    check("tick_push_cyc0", acc, 950);
    check("tick_push_level0", fifo_level, 1);
    wait_cyc(1002);

    // Reset during the second strobe cycle
    expect_period(24'hD00001, 1'b0);
    push_word(24'hD00001, acc);
    push_word(24'hD00002, acc);
    wait_cyc(1050);
    check("pre_rst_trig", sample_trig, 1);
    check("pre_rst_level", fifo_level, 1);
    wait_cyc(1051);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_trig", sample_trig, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_data_out", data_out, 0);
    reset = 1'b1;
    expect_period('0, 1'b1);
    wait_cyc(56);

    check("exp_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute backstop in case a wait loop is ever bypassed.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
